// File: rtl/ex_mem_pipe.sv
// EX/MEM pipeline register feeding the data RAM: registers EX results and
// control, with stall/flush handling, WB-to-store-data forwarding and load/store counters.
module ex_mem_pipe #(
    parameter int DATA_W  = 16,
    parameter int PC_W    = 8,
    parameter int CONST_W = 6,
    parameter int REG_AW  = 3,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stall,
    input  logic               flush,
    input  logic               ex_valid,
    input  logic [PC_W-1:0]    ex_pc,
    input  logic               ex_mem_read,
    input  logic               ex_mem_write,
    input  logic               ex_reg_write,
    input  logic [CONST_W-1:0] ex_constant,
    input  logic [DATA_W-1:0]  ex_rs_data,
    input  logic [REG_AW-1:0]  ex_rt,
    input  logic [DATA_W-1:0]  ex_rt_data,
    input  logic [REG_AW-1:0]  ex_rd,
    input  logic [DATA_W-1:0]  ex_alu_result,
    input  logic               wb_reg_write,
    input  logic [REG_AW-1:0]  wb_rd,
    input  logic [DATA_W-1:0]  wb_data,
    input  logic               cnt_clr,
    output logic [PC_W-1:0]    pc,
    output logic               mem_read,
    output logic               mem_write,
    output logic [CONST_W-1:0] constant,
    output logic [DATA_W-1:0]  rs_data,
    output logic [DATA_W-1:0]  data_in,
    output logic               mem_valid,
    output logic               mem_reg_write,
    output logic [REG_AW-1:0]  mem_rd,
    output logic [DATA_W-1:0]  mem_alu_result,
    output logic [CNT_W-1:0]   load_count,
    output logic [CNT_W-1:0]   store_count,
    output logic               ctrl_err
);

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [PC_W-1:0]    pc_r;
    logic               mem_read_r;
    logic               mem_write_r;
    logic [CONST_W-1:0] constant_r;
    logic [DATA_W-1:0]  rs_data_r;
    logic [DATA_W-1:0]  data_in_r;
    logic               mem_valid_r;
    logic               mem_reg_write_r;
    logic [REG_AW-1:0]  mem_rd_r;
    logic [DATA_W-1:0]  mem_alu_result_r;
    logic [CNT_W-1:0]   load_count_r;
    logic [CNT_W-1:0]   store_count_r;
    logic               ctrl_err_r;

    logic               capture_s;
    logic               illegal_s;
    logic               fwd_hit_s;
    logic [DATA_W-1:0]  store_data_s;
    logic               read_next_s;
    logic               write_next_s;
    logic               load_inc_s;
    logic               store_inc_s;

    // Decode capture conditions, illegal control and store-data forwarding.
    always_comb begin
        capture_s    = 1'b0;
        illegal_s    = 1'b0;
        fwd_hit_s    = 1'b0;
        store_data_s = ex_rt_data;
        read_next_s  = 1'b0;
        write_next_s = 1'b0;
        load_inc_s   = 1'b0;
        store_inc_s  = 1'b0;

        capture_s = ~flush & ~stall;
        illegal_s = ex_valid & ex_mem_read & ex_mem_write;
        fwd_hit_s = wb_reg_write & (wb_rd == ex_rt);
        if (fwd_hit_s) begin
            store_data_s = wb_data;
        end else begin
            store_data_s = ex_rt_data;
        end

        // A load+store combination is squashed to neither access.
        read_next_s  = ex_valid & ex_mem_read & ~illegal_s;
        write_next_s = ex_valid & ex_mem_write & ~illegal_s;

        if (capture_s) begin
            load_inc_s  = read_next_s & (load_count_r != CNT_MAX);
            store_inc_s = write_next_s & (store_count_r != CNT_MAX);
        end else begin
            load_inc_s  = 1'b0;
            store_inc_s = 1'b0;
        end
    end

    // Pipeline register: flush inserts a bubble, stall holds, otherwise capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_r             <= {PC_W{1'b0}};
            mem_read_r       <= 1'b0;
            mem_write_r      <= 1'b0;
            constant_r       <= {CONST_W{1'b0}};
            rs_data_r        <= {DATA_W{1'b0}};
            data_in_r        <= {DATA_W{1'b0}};
            mem_valid_r      <= 1'b0;
            mem_reg_write_r  <= 1'b0;
            mem_rd_r         <= {REG_AW{1'b0}};
            mem_alu_result_r <= {DATA_W{1'b0}};
        end else if (flush) begin
            pc_r             <= ex_pc;
            mem_read_r       <= 1'b0;
            mem_write_r      <= 1'b0;
            constant_r       <= ex_constant;
            rs_data_r        <= ex_rs_data;
            data_in_r        <= store_data_s;
            mem_valid_r      <= 1'b0;
            mem_reg_write_r  <= 1'b0;
            mem_rd_r         <= ex_rd;
            mem_alu_result_r <= ex_alu_result;
        end else if (stall) begin
            pc_r             <= pc_r;
            mem_read_r       <= mem_read_r;
            mem_write_r      <= mem_write_r;
            constant_r       <= constant_r;
            rs_data_r        <= rs_data_r;
            data_in_r        <= data_in_r;
            mem_valid_r      <= mem_valid_r;
            mem_reg_write_r  <= mem_reg_write_r;
            mem_rd_r         <= mem_rd_r;
            mem_alu_result_r <= mem_alu_result_r;
        end else begin
            pc_r             <= ex_pc;
            mem_read_r       <= read_next_s;
            mem_write_r      <= write_next_s;
            constant_r       <= ex_constant;
            rs_data_r        <= ex_rs_data;
            data_in_r        <= store_data_s;
            mem_valid_r      <= ex_valid;
            mem_reg_write_r  <= ex_valid & ex_reg_write;
            mem_rd_r         <= ex_rd;
            mem_alu_result_r <= ex_alu_result;
        end
    end

    // Saturating load counter; clear wins over increment and over stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_count_r <= CNT_ZERO;
        end else if (cnt_clr) begin
            load_count_r <= CNT_ZERO;
        end else if (load_inc_s) begin
            load_count_r <= load_count_r + CNT_ONE;
        end else begin
            load_count_r <= load_count_r;
        end
    end

    // Saturating store counter; clear wins over increment and over stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            store_count_r <= CNT_ZERO;
        end else if (cnt_clr) begin
            store_count_r <= CNT_ZERO;
        end else if (store_inc_s) begin
            store_count_r <= store_count_r + CNT_ONE;
        end else begin
            store_count_r <= store_count_r;
        end
    end

    // Sticky illegal-control flag, only cleared by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_err_r <= 1'b0;
        end else if (capture_s && illegal_s) begin
            ctrl_err_r <= 1'b1;
        end else begin
            ctrl_err_r <= ctrl_err_r;
        end
    end

    assign pc             = pc_r;
    assign mem_read       = mem_read_r;
    assign mem_write      = mem_write_r;
    assign constant       = constant_r;
    assign rs_data        = rs_data_r;
    assign data_in        = data_in_r;
    assign mem_valid      = mem_valid_r;
    assign mem_reg_write  = mem_reg_write_r;
    assign mem_rd         = mem_rd_r;
    assign mem_alu_result = mem_alu_result_r;
    assign load_count     = load_count_r;
    assign store_count    = store_count_r;
    assign ctrl_err       = ctrl_err_r;

endmodule

// File: tb/tb_ex_mem_pipe.sv
// Self-checking bench for ex_mem_pipe: directed steps plus random traffic
// compared against a behavioural model of the EX/MEM register.
module tb_ex_mem_pipe;

    logic        clk = 1'b0;
    logic        rst_n, stall, flush, ex_valid, ex_mem_read, ex_mem_write, ex_reg_write;
    logic [7:0]  ex_pc;
    logic [5:0]  ex_constant;
    logic [15:0] ex_rs_data, ex_rt_data, ex_alu_result, wb_data;
    logic [2:0]  ex_rt, ex_rd, wb_rd;
    logic        wb_reg_write, cnt_clr;
    logic [7:0]  pc;
    logic        mem_read, mem_write, mem_valid, mem_reg_write, ctrl_err;
    logic [5:0]  constant;
    logic [15:0] rs_data, data_in, mem_alu_result, load_count, store_count;
    logic [2:0]  mem_rd;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    logic [7:0]  m_pc;
    logic        m_rd, m_wr, m_valid, m_regw, m_err;
    logic [5:0]  m_const;
    logic [15:0] m_rs, m_din, m_alu;
    logic [2:0]  m_dst;
    int          m_lc, m_sc;

    always #5 clk = ~clk;

    ex_mem_pipe dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .ex_valid(ex_valid),
        .ex_pc(ex_pc), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_reg_write(ex_reg_write), .ex_constant(ex_constant), .ex_rs_data(ex_rs_data),
        .ex_rt(ex_rt), .ex_rt_data(ex_rt_data), .ex_rd(ex_rd), .ex_alu_result(ex_alu_result),
        .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data), .cnt_clr(cnt_clr),
        .pc(pc), .mem_read(mem_read), .mem_write(mem_write), .constant(constant),
        .rs_data(rs_data), .data_in(data_in), .mem_valid(mem_valid),
        .mem_reg_write(mem_reg_write), .mem_rd(mem_rd), .mem_alu_result(mem_alu_result),
        .load_count(load_count), .store_count(store_count), .ctrl_err(ctrl_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 8'h00; m_rd = 1'b0; m_wr = 1'b0; m_valid = 1'b0; m_regw = 1'b0;
        m_err = 1'b0; m_const = 6'h00; m_rs = 16'h0000; m_din = 16'h0000;
        m_alu = 16'h0000; m_dst = 3'h0; m_lc = 0; m_sc = 0;
    endtask

    // One clock edge of the intended behaviour, using the inputs currently driven.
    task automatic model_step();
        bit is_load, is_store, bad;
        bad      = ex_valid && ex_mem_read && ex_mem_write;
        is_load  = ex_valid && ex_mem_read && !bad;
        is_store = ex_valid && ex_mem_write && !bad;
        if (flush || !stall) begin
            m_pc    = ex_pc;
            m_const = ex_constant;
            m_rs    = ex_rs_data;
            m_din   = (wb_reg_write && wb_rd == ex_rt) ? wb_data : ex_rt_data;
            m_dst   = ex_rd;
            m_alu   = ex_alu_result;
            if (flush) begin
                m_valid = 1'b0; m_rd = 1'b0; m_wr = 1'b0; m_regw = 1'b0;
            end else begin
                m_valid = ex_valid;
                m_rd    = is_load;
                m_wr    = is_store;
                m_regw  = ex_valid && ex_reg_write;
                if (bad) m_err = 1'b1;
                if (is_load && m_lc < 65535) m_lc++;
                if (is_store && m_sc < 65535) m_sc++;
            end
        end
        if (cnt_clr) begin
            m_lc = 0;
            m_sc = 0;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all();
        chk("pc", 32'(pc), 32'(m_pc));
        chk("mem_read", 32'(mem_read), 32'(m_rd));
        chk("mem_write", 32'(mem_write), 32'(m_wr));
        chk("constant", 32'(constant), 32'(m_const));
        chk("rs_data", 32'(rs_data), 32'(m_rs));
        chk("data_in", 32'(data_in), 32'(m_din));
        chk("mem_valid", 32'(mem_valid), 32'(m_valid));
        chk("mem_reg_write", 32'(mem_reg_write), 32'(m_regw));
        chk("mem_rd", 32'(mem_rd), 32'(m_dst));
        chk("mem_alu_result", 32'(mem_alu_result), 32'(m_alu));
        chk("load_count", 32'(load_count), 32'(m_lc));
        chk("store_count", 32'(store_count), 32'(m_sc));
        chk("ctrl_err", 32'(ctrl_err), 32'(m_err));
    endtask

    task automatic idle();
        stall = 1'b0; flush = 1'b0; ex_valid = 1'b0; ex_mem_read = 1'b0;
        ex_mem_write = 1'b0; ex_reg_write = 1'b0; ex_pc = 8'h00; ex_constant = 6'h00;
        ex_rs_data = 16'h0000; ex_rt = 3'h0; ex_rt_data = 16'h0000; ex_rd = 3'h0;
        ex_alu_result = 16'h0000; wb_reg_write = 1'b0; wb_rd = 3'h0; wb_data = 16'h0000;
        cnt_clr = 1'b0;
    endtask

    task automatic randomize_ex();
        ex_valid      = ($urandom_range(3) != 0);
        ex_mem_read   = $urandom_range(1);
        ex_mem_write  = $urandom_range(1);
        ex_reg_write  = $urandom_range(1);
        ex_pc         = 8'($urandom);
        ex_constant   = 6'($urandom);
        ex_rs_data    = 16'($urandom);
        ex_rt         = 3'($urandom);
        ex_rt_data    = 16'($urandom);
        ex_rd         = 3'($urandom);
        ex_alu_result = 16'($urandom);
        wb_reg_write  = $urandom_range(1);
        wb_rd         = 3'($urandom);
        wb_data       = 16'($urandom);
    endtask

    task automatic set_load();
        idle();
        ex_valid = 1'b1; ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_pc = 8'h01;
        ex_constant = 6'h01; ex_rs_data = 16'h0002; ex_rd = 3'h2;
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        model_reset();
        #12;
        check_all();
        rst_n = 1'b1;

        // Single load
        set_load();
        tick();
        check_all();
        chk("plan_load_count", 32'(load_count), 32'h1);

        // Store with forwarding hit, then miss
        idle();
        ex_valid = 1'b1; ex_mem_write = 1'b1; ex_rt = 3'h3; ex_rt_data = 16'h1111;
        wb_reg_write = 1'b1; wb_rd = 3'h3; wb_data = 16'hBEEF;
        tick();
        check_all();
        chk("plan_fwd_hit", 32'(data_in), 32'hBEEF);
        wb_rd = 3'h4;
        tick();
        check_all();
        chk("plan_fwd_miss", 32'(data_in), 32'h1111);

        // Stall for three cycles while EX keeps changing
        for (int i = 0; i < 3; i++) begin
            randomize_ex();
            stall = 1'b1;
            tick();
            check_all();
        end
        chk("plan_stall_hold", 32'(data_in), 32'h1111);

        // Flush together with stall
        set_load();
        stall = 1'b1; flush = 1'b1;
        tick();
        check_all();
        chk("plan_flush_valid", 32'(mem_valid), 32'h0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            randomize_ex();
            stall   = ($urandom_range(4) == 0);
            flush   = ($urandom_range(7) == 0);
            cnt_clr = ($urandom_range(15) == 0);
            tick();
            check_all();
        end

        // Reset asserted mid-cycle with a store registered
        idle();
        ex_valid = 1'b1; ex_mem_write = 1'b1; ex_rt_data = 16'h5A5A;
        tick();
        chk("pre_reset_store", 32'(mem_write), 32'h1);
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all();
        #4;
        rst_n = 1'b1;

        // Illegal load+store, then legal loads keep the sticky flag
        idle();
        ex_valid = 1'b1; ex_mem_read = 1'b1; ex_mem_write = 1'b1; ex_reg_write = 1'b1;
        tick();
        check_all();
        chk("plan_illegal_err", 32'(ctrl_err), 32'h1);
        set_load();
        for (int i = 0; i < 10; i++) tick();
        check_all();

        // Saturation of the load counter
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        for (int i = 0; i < 16'hFFFE; i++) tick();
        check_all();
        chk("plan_preload", 32'(load_count), 32'hFFFE);
        for (int i = 0; i < 3; i++) tick();
        check_all();
        chk("plan_saturate", 32'(load_count), 32'hFFFF);

        // Clear beats a simultaneous load
        cnt_clr = 1'b1;
        tick();
        check_all();
        chk("plan_clr_wins", 32'(load_count), 32'h0);

        // Clear during stall still clears
        cnt_clr = 1'b0;
        tick();
        stall = 1'b1; cnt_clr = 1'b1;
        tick();
        check_all();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
